dp_responder: RTL and testbench

Responder end of the datapath (dp) instruction handshake. A drawing or ant-logic initiator drives `start_dp` and `instruction_dp`; this block accepts the instruction, executes it, and returns `finished_dp`/`result_dp`. Supported operations are memory load, memory store and pixel draw. It owns the shared data RAM port and the VGA adapter plot port, so every initiator reaches them through this one interface.

---
 rtl/dp_responder_pkg.sv | 37 +++
 rtl/dp_responder.sv | 190 +++++++++++++++++++
 tb/tb_dp_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_responder_pkg.sv
// Shared constants for the datapath instruction handshake: bus widths,
// opcode values, instruction field positions and the decoded-op type.
package dp_responder_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int RESULT_WIDTH      = 16;
  localparam int MEM_ADDR_WIDTH    = 16;
  localparam int X_COORD_WIDTH     = 8;
  localparam int Y_COORD_WIDTH     = 7;
  localparam int COLOUR_WIDTH      = 3;

  localparam int OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] DP_OP_NOP   = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] DP_OP_DRAW  = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] DP_OP_LOAD  = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] DP_OP_STORE = 4'd3;

  // Field positions inside the instruction word
  localparam int OPCODE_LSB       = 28;
  localparam int X_LSB            = 0;
  localparam int Y_LSB            = 8;
  localparam int COLOUR_LSB       = 15;
  localparam int PLOT_BIT         = 18;
  localparam int ADDR_LSB         = 0;
  localparam int STORE_DATA_LSB   = 16;
  localparam int STORE_DATA_WIDTH = 12;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_DRAW,
    OP_LOAD,
    OP_STORE,
    OP_ILLEGAL
  } op_kind_t;

endpackage

// File: rtl/dp_responder.sv
// Responder end of the datapath handshake. Accepts one instruction per
// start request, drives the shared RAM port or the VGA plot port, and
// reports completion on finished/result/illegal.
module dp_responder
  import dp_responder_pkg::*;
#(
  parameter int                      MEM_READ_LATENCY = 2,
  parameter logic [RESULT_WIDTH-1:0] ILLEGAL_RESULT   = 16'hFFFF
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         finished,
  output logic [RESULT_WIDTH-1:0]      result,
  output logic                         illegal,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_address,
  output logic [RESULT_WIDTH-1:0]      mem_data,
  output logic                         mem_wren,
  input  logic [RESULT_WIDTH-1:0]      mem_q,
  output logic [X_COORD_WIDTH-1:0]     vga_x,
  output logic [Y_COORD_WIDTH-1:0]     vga_y,
  output logic [COLOUR_WIDTH-1:0]      vga_colour,
  output logic                         vga_plot
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EXEC     = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  // The address is registered one edge before the read latency starts
  // counting, so the counter covers the remaining MEM_READ_LATENCY-1 edges.
  localparam int CNT_WIDTH = (MEM_READ_LATENCY > 2) ? $clog2(MEM_READ_LATENCY) : 1;
  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(MEM_READ_LATENCY - 1);

  logic [1:0]                   state;
  logic                         armed;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
  logic [CNT_WIDTH-1:0]         wait_cnt;

  op_kind_t new_op;
  op_kind_t cur_op;
  logic     accept;
  logic     load_done;

  function automatic op_kind_t decode_op(input logic [OPCODE_WIDTH-1:0] opcode);
    // NOTE: the default arm makes the decode total, so every opcode maps to
    // a defined kind and no storage is implied for unlisted values.
    case (opcode)
      DP_OP_NOP:   return OP_NOP;
      DP_OP_DRAW:  return OP_DRAW;
      DP_OP_LOAD:  return OP_LOAD;
      DP_OP_STORE: return OP_STORE;
      default:     return OP_ILLEGAL;
    endcase
  endfunction

  // Decode the incoming and latched opcodes and form the accept condition.
  always_comb begin
    new_op    = decode_op(instruction[OPCODE_LSB +: OPCODE_WIDTH]);
    cur_op    = decode_op(instr_q[OPCODE_LSB +: OPCODE_WIDTH]);
    accept    = (state == S_IDLE) && start && armed;
    load_done = (state == S_MEM_WAIT) && (wait_cnt == '0);
  end

  // Armed flag: an initiator holds start for two cycles, so a new request is
  // only honoured after start has been seen low since the last acceptance.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: every sequential assignment is non-blocking so all registers
    // update together from the values sampled at the same edge.
    if (!resetn) begin
      armed <= 1'b1;
    end else if (accept) begin
      armed <= 1'b0;
    end else if (!start) begin
      armed <= 1'b1;
    end
  end

  // Control FSM with the read-latency counter; LOAD completes straight from
  // MEM_WAIT so finished rises on the same edge that captures mem_q.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      instr_q  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            instr_q <= instruction;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cur_op == OP_LOAD) begin
            wait_cnt <= WAIT_LOAD;
            state    <= S_MEM_WAIT;
          end else begin
            state <= S_DONE;
          end
        end
        S_MEM_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - CNT_WIDTH'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs: finished drops at acceptance and rises on return to
  // IDLE; result/illegal change only at acceptance or at the load capture.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      finished <= 1'b1;
      result   <= '0;
      illegal  <= 1'b0;
    end else if (accept) begin
      finished <= 1'b0;
      illegal  <= (new_op == OP_ILLEGAL);
      if (new_op == OP_ILLEGAL) begin
        result <= ILLEGAL_RESULT;
      end else if (new_op != OP_LOAD) begin
        result <= '0;
      end
    end else if (load_done) begin
      result   <= mem_q;
      finished <= 1'b1;
    end else if (state == S_DONE) begin
      finished <= 1'b1;
    end
  end

  // RAM port: address/data are held between operations, the write enable
  // is a single-cycle pulse issued from EXEC.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      if (state == S_EXEC) begin
        case (cur_op)
          OP_LOAD: begin
            mem_address <= instr_q[ADDR_LSB +: MEM_ADDR_WIDTH];
          end
          OP_STORE: begin
            mem_address <= instr_q[ADDR_LSB +: MEM_ADDR_WIDTH];
            mem_data    <= {{(RESULT_WIDTH - STORE_DATA_WIDTH){1'b0}},
                            instr_q[STORE_DATA_LSB +: STORE_DATA_WIDTH]};
            mem_wren    <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // VGA port: coordinates are held after a DRAW, plot is a single-cycle
  // pulse gated by the instruction's plot-enable bit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      if ((state == S_EXEC) && (cur_op == OP_DRAW)) begin
        vga_x      <= instr_q[X_LSB +: X_COORD_WIDTH];
        vga_y      <= instr_q[Y_LSB +: Y_COORD_WIDTH];
        vga_colour <= instr_q[COLOUR_LSB +: COLOUR_WIDTH];
        vga_plot   <= instr_q[PLOT_BIT];
      end
    end
  end

endmodule

// File: tb/tb_dp_responder.sv
// Self-checking bench for dp_responder: a transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, then a
// randomized start/instruction stream.
module tb_dp_responder;
  import dp_responder_pkg::*;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic [31:0] instruction = '0;
  logic        finished;
  logic [15:0] result;
  logic        illegal;
  logic [15:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic [15:0] mem_q;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  always #5 clock = ~clock;

  dp_responder #(
    .MEM_READ_LATENCY(LAT),
    .ILLEGAL_RESULT  (16'hFFFF)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .instruction(instruction),
    .finished   (finished),
    .result     (result),
    .illegal    (illegal),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- synchronous RAM stub (address registered by DUT, one output register here)
  function automatic logic [15:0] ram_init(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  logic [15:0] ram [int];
  logic [15:0] ram_q = '0;
  assign mem_q = ram_q;

  always @(posedge clock) begin
    ram_q <= ram.exists(int'(mem_address)) ? ram[int'(mem_address)] : ram_init(mem_address);
    if (mem_wren) ram[int'(mem_address)] = mem_data;
  end

  // ---------------- edge counter and pulse counters (read by the directed driver)
  int edge_cnt = 0;
  int wren_cnt = 0;
  int plot_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;
  always @(negedge clock) begin
    wren_cnt <= wren_cnt + int'(mem_wren);
    plot_cnt <= plot_cnt + int'(vga_plot);
  end

  // ---------------- reference model: schedules each accepted instruction's
  // effects by cycle offset from its acceptance edge.
  logic        m_fin, m_illegal, m_wren, m_plot, m_armed, m_pending;
  logic [15:0] m_result, m_res_next, m_addr, m_data;
  logic [7:0]  m_x;
  logic [6:0]  m_y;
  logic [2:0]  m_col;
  logic [31:0] m_instr;
  int          m_cyc, m_t_acc, m_t_done;
  logic [15:0] m_mem [int];

  function automatic logic [15:0] model_read(input logic [15:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : ram_init(a);
  endfunction

  task automatic model_reset();
    m_fin = 1'b1; m_illegal = 1'b0; m_wren = 1'b0; m_plot = 1'b0;
    m_armed = 1'b1; m_pending = 1'b0; m_result = '0; m_res_next = '0;
    m_addr = '0; m_data = '0; m_x = '0; m_y = '0; m_col = '0; m_instr = '0;
  endtask

  task automatic model_step();
    logic       was_idle;
    logic [3:0] op;
    was_idle = m_fin;
    m_cyc++;
    m_wren = 1'b0;
    m_plot = 1'b0;
    if (m_pending && m_cyc == m_t_acc + 1) begin
      op = m_instr[31:28];
      if (op == DP_OP_DRAW) begin
        m_x = m_instr[7:0]; m_y = m_instr[14:8]; m_col = m_instr[17:15]; m_plot = m_instr[18];
      end else if (op == DP_OP_LOAD) begin
        m_addr = m_instr[15:0];
      end else if (op == DP_OP_STORE) begin
        m_addr = m_instr[15:0]; m_data = {4'h0, m_instr[27:16]}; m_wren = 1'b1;
      end
    end
    if (m_pending && m_cyc == m_t_done) begin
      m_fin = 1'b1;
      m_result = m_res_next;
      m_pending = 1'b0;
    end
    if (was_idle && start && m_armed) begin
      m_instr   = instruction;
      op        = instruction[31:28];
      m_t_acc   = m_cyc;
      m_t_done  = m_cyc + ((op == DP_OP_LOAD) ? 1 + LAT : 2);
      m_fin     = 1'b0;
      m_armed   = 1'b0;
      m_pending = 1'b1;
      m_illegal = (op > 4'd3);
      if (op == DP_OP_LOAD) m_res_next = model_read(instruction[15:0]);
      else if (op > 4'd3) m_res_next = 16'hFFFF;
      else m_res_next = 16'h0000;
      if (op == DP_OP_STORE) m_mem[int'(instruction[15:0])] = {4'h0, instruction[27:16]};
    end else if (!start) begin
      m_armed = 1'b1;
    end
  endtask

  initial begin
    m_cyc = 0; m_t_acc = 0; m_t_done = 0;
    model_reset();
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle comparison against the model
  always @(negedge clock) begin
    if (resetn) begin
      check("finished",    32'(finished),    32'(m_fin));
      check("mem_wren",    32'(mem_wren),    32'(m_wren));
      check("vga_plot",    32'(vga_plot),    32'(m_plot));
      check("mem_address", 32'(mem_address), 32'(m_addr));
      check("mem_data",    32'(mem_data),    32'(m_data));
      check("vga_x",       32'(vga_x),       32'(m_x));
      check("vga_y",       32'(vga_y),       32'(m_y));
      check("vga_colour",  32'(vga_colour),  32'(m_col));
      if (m_fin) begin
        check("result",  32'(result),  32'(m_result));
        check("illegal", 32'(illegal), 32'(m_illegal));
      end
    end
  end

  // ---------------- directed helpers
  task automatic issue(input logic [31:0] ins, input int hold, output int t_idx);
    @(negedge clock);
    instruction = ins;
    start = 1'b1;
    @(posedge clock);
    t_idx = edge_cnt;
    repeat (hold - 1) @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_finished(input string name, input int t_idx, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (finished) break;
      @(negedge clock);
    end
    check({name, "_done"}, 32'(finished), 32'd1);
    if (finished) lat = edge_cnt - t_idx - 1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [3:0]  op;
    logic [15:0] a;
    int          r;
    w = $urandom;
    r = $urandom_range(0, 15);
    if (r < 13) op = 4'(r % 4);
    else op = 4'($urandom_range(4, 15));
    a = {($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00, 4'h0, 4'($urandom_range(0, 15))};
    w[31:28] = op;
    if (op == DP_OP_LOAD || op == DP_OP_STORE) w[15:0] = a;
    return w;
  endfunction

  // ---------------- stimulus
  initial begin
    int t, lat, w0, p0;
    #1 resetn = 1'b0;
    #1;
    check("rst_finished", 32'(finished), 32'd1);
    check("rst_result",   32'(result),   32'd0);
    check("rst_illegal",  32'(illegal),  32'd0);
    check("rst_wren",     32'(mem_wren), 32'd0);
    check("rst_plot",     32'(vga_plot), 32'd0);
    check("rst_addr",     32'(mem_address), 32'd0);
    repeat (2) @(negedge clock);
    #2 resetn = 1'b1;
    @(negedge clock);

    // STORE then LOAD of the same word
    w0 = wren_cnt;
    issue({4'd3, 12'hABC, 16'h0010}, 1, t);
    wait_finished("store", t, lat);
    check("store_latency", 32'(lat), 32'd2);
    repeat (2) @(negedge clock);
    check("store_wren_pulses", 32'(wren_cnt - w0), 32'd1);
    check("store_addr", 32'(mem_address), 32'h0010);
    check("store_data", 32'(mem_data), 32'h0ABC);

    issue({4'd2, 12'd0, 16'h0010}, 1, t);
    wait_finished("load", t, lat);
    check("load_latency", 32'(lat), 32'd3);
    check("load_result", 32'(result), 32'h0ABC);
    check("load_illegal", 32'(illegal), 32'd0);

    // DRAW with and without plot enable
    p0 = plot_cnt;
    issue({4'd1, 9'd0, 1'b1, 3'b011, 7'd50, 8'd100}, 1, t);
    wait_finished("draw", t, lat);
    check("draw_latency", 32'(lat), 32'd2);
    repeat (2) @(negedge clock);
    check("draw_plot_pulses", 32'(plot_cnt - p0), 32'd1);
    check("draw_x", 32'(vga_x), 32'd100);
    check("draw_y", 32'(vga_y), 32'd50);
    check("draw_colour", 32'(vga_colour), 32'd3);
    check("draw_result", 32'(result), 32'd0);

    p0 = plot_cnt;
    issue({4'd1, 9'd0, 1'b0, 3'b011, 7'd50, 8'd100}, 1, t);
    wait_finished("draw_noplot", t, lat);
    check("draw_noplot_latency", 32'(lat), 32'd2);
    repeat (2) @(negedge clock);
    check("draw_noplot_pulses", 32'(plot_cnt - p0), 32'd0);

    // Two-cycle start hold executes once
    w0 = wren_cnt;
    issue({4'd3, 12'h123, 16'h0020}, 2, t);
    wait_finished("hold2", t, lat);
    check("hold2_latency", 32'(lat), 32'd2);
    repeat (2) @(negedge clock);
    check("hold2_wren_pulses", 32'(wren_cnt - w0), 32'd1);

    // Start held across finished does not retrigger
    w0 = wren_cnt;
    issue({4'd3, 12'h456, 16'h0021}, 6, t);
    repeat (2) @(negedge clock);
    check("hold6_wren_pulses", 32'(wren_cnt - w0), 32'd1);
    check("hold6_finished", 32'(finished), 32'd1);

    // Start pulse during MEM_WAIT is ignored and not queued
    w0 = wren_cnt;
    issue({4'd2, 12'd0, 16'h0020}, 1, t);
    @(negedge clock);
    instruction = {4'd3, 12'hFFF, 16'h0021};
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_finished("busy", t, lat);
    check("busy_latency", 32'(lat), 32'd3);
    check("busy_result", 32'(result), 32'h0123);
    repeat (3) @(negedge clock);
    check("busy_still_finished", 32'(finished), 32'd1);
    check("busy_no_write", 32'(wren_cnt - w0), 32'd0);

    // Illegal opcode, then NOP clears illegal
    w0 = wren_cnt;
    p0 = plot_cnt;
    issue({4'd9, 28'h1234567}, 1, t);
    wait_finished("illegal", t, lat);
    check("illegal_latency", 32'(lat), 32'd2);
    check("illegal_result", 32'(result), 32'hFFFF);
    check("illegal_flag", 32'(illegal), 32'd1);
    repeat (2) @(negedge clock);
    check("illegal_no_mem", 32'(wren_cnt - w0), 32'd0);
    check("illegal_no_vga", 32'(plot_cnt - p0), 32'd0);
    issue(32'h0000_0000, 1, t);
    wait_finished("nop", t, lat);
    check("nop_clears_illegal", 32'(illegal), 32'd0);
    check("nop_result", 32'(result), 32'd0);

    // Reset while a STORE pulse is on the bus
    issue({4'd3, 12'h777, 16'h1234}, 1, t);
    @(negedge clock);
    check("pre_reset_wren", 32'(mem_wren), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("abort_store_wren", 32'(mem_wren), 32'd0);
    check("abort_store_finished", 32'(finished), 32'd1);
    @(negedge clock);
    #2 resetn = 1'b1;

    // Reset in the middle of a LOAD
    issue({4'd2, 12'd0, 16'h0010}, 1, t);
    @(negedge clock);
    check("pre_reset_busy", 32'(finished), 32'd0);
    #2 resetn = 1'b0;
    #1;
    check("abort_load_finished", 32'(finished), 32'd1);
    check("abort_load_result", 32'(result), 32'd0);
    check("abort_load_wren", 32'(mem_wren), 32'd0);
    check("abort_load_plot", 32'(vga_plot), 32'd0);
    check("abort_load_addr", 32'(mem_address), 32'd0);
    @(negedge clock);
    #2 resetn = 1'b1;
    @(negedge clock);
    check("post_reset_idle", 32'(finished), 32'd1);
    issue(32'h0000_0000, 1, t);
    wait_finished("post_reset_nop", t, lat);
    check("post_reset_nop_latency", 32'(lat), 32'd2);

    // Randomized start/instruction stream checked by the model
    for (int i = 0; i < 2500; i++) begin
      @(negedge clock);
      start = ($urandom_range(0, 1) == 1);
      instruction = rand_instr();
    end
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
